// File: rtl/spi_flash_read.sv
// Serial NOR flash read sequencer: feeds command/address/filler bytes to spi_master
// and returns the payload bytes. Define SPI_FLASH_FAST_READ_EN for 0x0B fast read.
module spi_flash_read #(
  parameter int LW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [23:0]   addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [7:0]    tx_data,
  input  logic          tx_get,
  output logic          tx_empty,
  input  logic [7:0]    rx_data,
  input  logic          rx_put,
  output logic [7:0]    data,
  output logic          valid
);

  localparam int CW = LW + 1;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0]    CMD = 8'h0B;
  localparam logic [CW-1:0] HDR = CW'(5);
`else
  localparam logic [7:0]    CMD = 8'h03;
  localparam logic [CW-1:0] HDR = CW'(4);
`endif

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    FILL,
    DRAIN,
    FIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [23:0]   addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tx_take;
  logic          rx_take;
  logic [CW-1:0] tx_cnt_dec;
  logic [CW-1:0] tx_pos;
  logic [7:0]    next_byte;

  // Combinational so the master sees the next word in the very cycle it takes one.
  assign tx_empty = (tx_cnt_q == '0) || (state_q == IDLE) || (state_q == FIN);

  assign tx_take    = tx_get && !tx_empty;
  assign rx_take    = rx_put && (rx_cnt_q != '0) &&
                      (state_q == HEAD || state_q == FILL || state_q == DRAIN);
  assign tx_cnt_dec = tx_cnt_q - CW'(1);
  // Stream position of the byte that follows the one being taken now.
  assign tx_pos     = HDR + {1'b0, len_q} - tx_cnt_dec;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_byte = 8'h00;
    if (tx_pos == CW'(1))      next_byte = addr_q[23:16];
    else if (tx_pos == CW'(2)) next_byte = addr_q[15:8];
    else if (tx_pos == CW'(3)) next_byte = addr_q[7:0];
  end

  always_comb begin
    state_d   = state_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    tx_data_d = tx_data_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = HEAD;
            addr_d    = addr;
            len_d     = len;
            tx_cnt_d  = HDR + {1'b0, len};
            rx_cnt_d  = HDR + {1'b0, len};
            tx_data_d = CMD;
          end
        end
      end
      HEAD: begin
        if (tx_take) begin
          tx_cnt_d  = tx_cnt_dec;
          tx_data_d = next_byte;
          if (tx_cnt_dec == {1'b0, len_q}) state_d = FILL;
        end
      end
      FILL: begin
        if (tx_take) begin
          tx_cnt_d  = tx_cnt_dec;
          tx_data_d = next_byte;
          if (tx_cnt_dec == '0) state_d = DRAIN;
        end
      end
      DRAIN: ;
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (rx_take) begin
      rx_cnt_d = rx_cnt_q - CW'(1);
      // Header echo bytes arrive while more than len bytes are still outstanding.
      if (rx_cnt_q <= {1'b0, len_q}) begin
        data_d  = rx_data;
        valid_d = 1'b1;
      end
    end

    if (state_d == DRAIN && rx_cnt_d == '0) state_d = FIN;

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      tx_data_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      tx_data_q <= tx_data_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign tx_data = tx_data_q;
  assign data    = data_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_spi_flash_read.sv
// Bench for spi_flash_read: emulates spi_master plus a behavioural flash behind it
// and checks the transmitted stream, returned bytes and done/busy handshakes.
module tb_spi_flash_read;

  localparam int LW = 16;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam int         H   = 5;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         H   = 4;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy, done, tx_empty, valid;
  logic [7:0]    tx_data, data;
  logic          tx_get = 1'b0;
  logic          rx_put = 1'b0;
  logic [7:0]    rx_data = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  spi_flash_read #(.LW(LW)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .start    (start),
    .addr     (addr_i),
    .len      (len_i),
    .busy     (busy),
    .done     (done),
    .tx_data  (tx_data),
    .tx_get   (tx_get),
    .tx_empty (tx_empty),
    .rx_data  (rx_data),
    .rx_put   (rx_put),
    .data     (data),
    .valid    (valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash array contents as a pure function of the byte address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return 8'((a * 13) + (a >> 11) + 32'h5A);
  endfunction

  // Master + flash: one word per chip-select session, cs released once tx_empty is seen.
  task automatic master(input int abort_at, output int nbytes);
    logic [7:0]  pend;
    logic [7:0]  resp;
    logic [23:0] fa;
    bit          have;
    int          guard;
    have   = 1'b0;
    guard  = 0;
    nbytes = 0;
    pend   = '0;
    while (guard < 5000) begin
      guard++;
      if (!tx_empty) begin
        txq.push_back(tx_data);
        if (nbytes < H || txq[0] != CMD) begin
          resp = 8'hFF;
        end else begin
          fa   = {txq[1], txq[2], txq[3]};
          resp = flash_byte(fa + 24'(nbytes - H));
        end
        tx_get = 1'b1;
        if (have) begin
          rx_put  = 1'b1;
          rx_data = pend;
        end
        pend = resp;
        have = 1'b1;
        nbytes++;
        @(negedge clk);
        tx_get = 1'b0;
        rx_put = 1'b0;
        if (nbytes == abort_at) begin
          rst_n = 1'b0;
          return;
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end else if (have) begin
        rx_put  = 1'b1;
        rx_data = pend;
        @(negedge clk);
        rx_put = 1'b0;
        return;
      end else begin
        @(negedge clk);
      end
    end
    check("master_timeout", 1, 0);
  endtask

  task automatic monitor(output int ndone);
    int guard;
    guard = 0;
    ndone = 0;
    while (ndone == 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (valid) rxq.push_back(data);
      if (done) begin
        ndone++;
        check("busy_low_at_done", busy, 0);
      end
    end
    if (ndone == 0) check("done_timeout", 1, 0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input bit poke);
    int         nb, nd;
    logic [7:0] exp_b;
    txq.delete();
    rxq.delete();
    start  = 1'b1;
    addr_i = a;
    len_i  = LW'(n);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("tx_empty_after_start", tx_empty, 0);
    check("first_tx_byte", tx_data, CMD);
    fork
      master(0, nb);
      monitor(nd);
      if (poke) begin
        repeat (6) @(negedge clk);
        start  = 1'b1;
        addr_i = 24'h000000;
        len_i  = LW'(5);
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("tx_byte_count", nb, H + n);
    for (int i = 0; i < txq.size(); i++) begin
      case (i)
        0:       exp_b = CMD;
        1:       exp_b = a[23:16];
        2:       exp_b = a[15:8];
        3:       exp_b = a[7:0];
        default: exp_b = 8'h00;
      endcase
      check($sformatf("tx_byte[%0d]", i), txq[i], exp_b);
    end
    check("rx_byte_count", rxq.size(), n);
    for (int i = 0; i < rxq.size() && i < n; i++)
      check($sformatf("rx_byte[%0d]", i), rxq[i], flash_byte(a + 24'(i)));
    check("done_count", nd, 1);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_data", data, 0);
    check("rst_tx_data", tx_data, 0);

    do_read(24'h123456, 3, 1'b0);

    start  = 1'b1;
    addr_i = 24'hABCDEF;
    len_i  = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_len_done", done, 1);
    check("zero_len_busy", busy, 0);
    check("zero_len_tx_empty", tx_empty, 1);
    @(negedge clk);
    check("zero_len_done_pulse", done, 0);
    repeat (4) begin
      @(negedge clk);
      check("zero_len_idle_empty", tx_empty, 1);
    end

    do_read(24'h00ABCD, 6, 1'b1);

    txq.delete();
    start  = 1'b1;
    addr_i = 24'h200000;
    len_i  = LW'(8);
    @(negedge clk);
    start = 1'b0;
    master(5, nb);
    #1;
    check("abort_bytes", nb, 5);
    check("abort_tx_empty", tx_empty, 1);
    check("abort_busy", busy, 0);
    check("abort_tx_data", tx_data, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_read(24'hFFFFFE, 1, 1'b0);

    do_read(24'h000010, 2, 1'b0);
    do_read(24'hFFFFFE, 3, 1'b0);

    // Back-to-back random reads: each start lands in the cycle done is high.
    for (int k = 0; k < 8; k++)
      do_read(24'($urandom), $urandom_range(1, 12), 1'b0);

    do_read(24'h7FFF00, 300, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
